// File: rtl/lc_pkg.sv
// Shared lifecycle-controller types, default per-state owner signatures and the target-legality helper.
package lc_pkg;

  localparam int LC_ID_W_MAX = 256;
  localparam int LC_NUM_SIG  = 6;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CHECK,
    DONE,
    LOCKED
  } lc_fsm_t;

  localparam logic [LC_ID_W_MAX-1:0] LC_SIG_DEFAULT [LC_NUM_SIG] = '{
    {64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 64'hA5A5_0F0F_5A5A_F0F0, 64'h0000_0000_0000_0C00},
    {64'hFEDC_BA98_7654_3210, 64'h5555_6666_7777_8888, 64'h3C3C_C3C3_1234_ABCD, 64'h0000_0000_0000_0C01},
    {64'hDEAD_BEEF_CAFE_F00D, 64'h9999_AAAA_BBBB_CCCC, 64'h0F1E_2D3C_4B5A_6978, 64'h0000_0000_0000_0C02},
    {64'h8BAD_F00D_0BAD_CAFE, 64'hDDDD_EEEE_FFFF_0000, 64'h8796_A5B4_C3D2_E1F0, 64'h0000_0000_0000_0C03},
    {64'h1357_9BDF_2468_ACE0, 64'h0246_8ACE_1357_9BDF, 64'hC001_D00D_FACE_B00C, 64'h0000_0000_0000_0C04},
    {64'hE0E0_1F1F_E0E0_1F1F, 64'h7654_3210_FEDC_BA98, 64'h600D_F00D_BAAD_D00D, 64'h0000_0000_0000_0C05}
  };

  // States beyond the default table get a generated, still-unique signature.
  function automatic logic [LC_ID_W_MAX-1:0] lc_sig_default(input int unsigned idx);
    if (idx < LC_NUM_SIG) return LC_SIG_DEFAULT[idx[2:0]];
    return {8{idx ^ 32'hC3C3_0000}};
  endfunction

  function automatic logic lc_target_legal(input int unsigned cur,
                                           input int unsigned tgt,
                                           input int unsigned num_states,
                                           input logic        allow_skip);
    return (tgt > cur) && (tgt <= num_states - 1) && (allow_skip || (tgt == cur + 1));
  endfunction

endpackage

// File: rtl/lc_sig_store.sv
// Read-only owner-signature store: one lookup per rd_en, data qualified by valid RD_LAT cycles later.
module lc_sig_store
  import lc_pkg::*;
#(
  parameter  int ID_W       = 256,
  parameter  int NUM_STATES = 6,
  parameter  int RD_LAT     = 2,
  localparam int STATE_W    = $clog2(NUM_STATES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic [STATE_W-1:0] addr,
  output logic [ID_W-1:0]    rdata,
  output logic               valid
);

  logic [RD_LAT-1:0]      vld_q, vld_d;
  logic [STATE_W-1:0]     addr_q, addr_d;
  logic [LC_ID_W_MAX-1:0] word;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    addr_d    = rd_en ? addr : addr_q;
    vld_d     = vld_q << 1;
    vld_d[0]  = rd_en;
    word      = lc_sig_default(32'(addr_q));
    rdata     = word[ID_W-1:0];
  end

  assign valid = vld_q[RD_LAT-1];

  // NOTE: ROM contents are constants, so only the address and valid pipeline need a reset.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      addr_q <= '0;
    end else begin
      vld_q  <= vld_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/lc_transition_ctrl.sv
// Lifecycle state controller: authenticates transition requests against per-state signatures,
// counts failed authentications and locks permanently after MAX_FAILS.
module lc_transition_ctrl
  import lc_pkg::*;
#(
  parameter  int ID_W       = 256,
  parameter  int NUM_STATES = 6,
  parameter  int RD_LAT     = 2,
  parameter  int MAX_FAILS  = 3,
  parameter  int ALLOW_SKIP = 0,
  parameter  int DEBUG_MAX  = 1,
  localparam int STATE_W    = $clog2(NUM_STATES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               lc_transition_request,
  input  logic [STATE_W-1:0] lc_target,
  input  logic [ID_W-1:0]    lc_identifier,
  output logic [STATE_W-1:0] lc_state,
  output logic               lc_success,
  output logic               lc_fail,
  output logic               lc_locked,
  output logic               lc_busy,
  output logic               lc_debug_en
);

  localparam int                 FC_W     = $clog2(MAX_FAILS + 1);
  localparam logic [STATE_W-1:0] EOL      = STATE_W'(NUM_STATES - 1);
  localparam logic [FC_W-1:0]    FAIL_SAT = FC_W'(MAX_FAILS);

  lc_fsm_t            state_q, state_d;
  logic [STATE_W-1:0] lc_state_q, lc_state_d;
  logic [STATE_W-1:0] tgt_q, tgt_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    sig_q, sig_d;
  logic [FC_W-1:0]    fail_cnt_q, fail_cnt_d;
  logic               success_q, success_d;
  logic               fail_q, fail_d;
  logic               debug_en_q, debug_en_d;

  logic               rd_en;
  logic               sig_valid;
  logic [ID_W-1:0]    sig_rdata;
  logic               id_match;
  logic               tgt_ok;

  lc_sig_store #(
    .ID_W      (ID_W),
    .NUM_STATES(NUM_STATES),
    .RD_LAT    (RD_LAT)
  ) u_sig_store (
    .clk  (clk),
    .rst  (rst),
    .rd_en(rd_en),
    .addr (lc_state_q),
    .rdata(sig_rdata),
    .valid(sig_valid)
  );

  assign id_match = (id_q == sig_q);
  assign tgt_ok   = lc_target_legal(32'(lc_state_q), 32'(tgt_q), 32'(NUM_STATES), ALLOW_SKIP != 0);

  always_comb begin
    state_d    = state_q;
    lc_state_d = lc_state_q;
    tgt_d      = tgt_q;
    id_d       = id_q;
    sig_d      = sig_q;
    fail_cnt_d = fail_cnt_q;
    success_d  = success_q;
    fail_d     = fail_q;
    rd_en      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (lc_transition_request) begin
          id_d    = lc_identifier;
          tgt_d   = lc_target;
          rd_en   = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (sig_valid) begin
          sig_d   = sig_rdata;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (id_match && tgt_ok) begin
          lc_state_d = tgt_q;
          fail_cnt_d = '0;
          success_d  = 1'b1;
        end else begin
          fail_d = 1'b1;
          // Only a wrong identifier counts as an attack; EOL requests never move the counter.
          if (!id_match && (lc_state_q != EOL) && (fail_cnt_q != FAIL_SAT))
            fail_cnt_d = fail_cnt_q + 1'b1;
        end
        id_d    = '0;
        state_d = DONE;
      end
      DONE: begin
        if (!lc_transition_request) begin
          success_d = 1'b0;
          fail_d    = 1'b0;
          state_d   = (fail_cnt_q == FAIL_SAT) ? LOCKED : IDLE;
        end
      end
      LOCKED:  state_d = LOCKED;
      default: state_d = IDLE;
    endcase

    debug_en_d = (32'(lc_state_d) <= DEBUG_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lc_state_q <= '0;
      tgt_q      <= '0;
      id_q       <= '0;
      sig_q      <= '0;
      fail_cnt_q <= '0;
      success_q  <= 1'b0;
      fail_q     <= 1'b0;
      debug_en_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      lc_state_q <= lc_state_d;
      tgt_q      <= tgt_d;
      id_q       <= id_d;
      sig_q      <= sig_d;
      fail_cnt_q <= fail_cnt_d;
      success_q  <= success_d;
      fail_q     <= fail_d;
      debug_en_q <= debug_en_d;
    end
  end

  assign lc_state    = lc_state_q;
  assign lc_success  = success_q;
  assign lc_fail     = fail_q;
  assign lc_locked   = (state_q == LOCKED);
  assign lc_busy     = (state_q == FETCH) || (state_q == CHECK) || (state_q == DONE);
  assign lc_debug_en = debug_en_q;

endmodule

// File: tb/tb_lc_transition_ctrl.sv
// Self-checking bench for lc_transition_ctrl: one instance with single-step targets, one with skipping enabled.
module tb_lc_transition_ctrl;
  import lc_pkg::*;

  localparam int ID_W       = 256;
  localparam int NUM_STATES = 6;
  localparam int STATE_W    = 3;
  localparam int RD_LAT     = 2;
  localparam int MAX_FAILS  = 3;
  localparam int DEBUG_MAX  = 1;
  localparam int TIMEOUT    = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst  [2];
  logic               req  [2];
  logic [STATE_W-1:0] tgt  [2];
  logic [ID_W-1:0]    id   [2];
  logic [STATE_W-1:0] st   [2];
  logic               succ [2];
  logic               fl   [2];
  logic               lck  [2];
  logic               bsy  [2];
  logic               dbg  [2];

  lc_transition_ctrl #(
    .ID_W(ID_W), .NUM_STATES(NUM_STATES), .RD_LAT(RD_LAT),
    .MAX_FAILS(MAX_FAILS), .ALLOW_SKIP(0), .DEBUG_MAX(DEBUG_MAX)
  ) u0 (
    .clk(clk), .rst(rst[0]), .lc_transition_request(req[0]), .lc_target(tgt[0]),
    .lc_identifier(id[0]), .lc_state(st[0]), .lc_success(succ[0]), .lc_fail(fl[0]),
    .lc_locked(lck[0]), .lc_busy(bsy[0]), .lc_debug_en(dbg[0])
  );

  lc_transition_ctrl #(
    .ID_W(ID_W), .NUM_STATES(NUM_STATES), .RD_LAT(RD_LAT),
    .MAX_FAILS(MAX_FAILS), .ALLOW_SKIP(1), .DEBUG_MAX(DEBUG_MAX)
  ) u1 (
    .clk(clk), .rst(rst[1]), .lc_transition_request(req[1]), .lc_target(tgt[1]),
    .lc_identifier(id[1]), .lc_state(st[1]), .lc_success(succ[1]), .lc_fail(fl[1]),
    .lc_locked(lck[1]), .lc_busy(bsy[1]), .lc_debug_en(dbg[1])
  );

  typedef struct {
    logic ok;
    int   state;
    logic dbg;
    logic lock;
  } exp_t;

  typedef struct {
    int   inst;
    int   tgt;
    int   sig;
    logic bad_id;
    logic ok;
    int   state;
    int   fcnt;
    logic lock;
  } vec_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [ID_W-1:0] ident(input int sig, input logic bad);
    logic [ID_W-1:0] v;
    v = LC_SIG_DEFAULT[sig];
    if (bad) v = v ^ (256'(1) << 200);
    return v;
  endfunction

  function automatic int fail_cnt(input int inst);
    return (inst == 0) ? int'(u0.fail_cnt_q) : int'(u1.fail_cnt_q);
  endfunction

  task automatic check_idle(input string name, input int inst, input int state, input logic locked);
    check({name, " success"}, 32'(succ[inst]), 32'(1'b0));
    check({name, " fail"},    32'(fl[inst]),   32'(1'b0));
    check({name, " busy"},    32'(bsy[inst]),  32'(1'b0));
    check({name, " locked"},  32'(lck[inst]),  32'(locked));
    check({name, " state"},   32'(st[inst]),   32'(state));
    check({name, " debug"},   32'(dbg[inst]),  32'(state <= DEBUG_MAX));
  endtask

  task automatic do_reset(input int inst);
    @(negedge clk);
    rst[inst] = 1'b1;
    req[inst] = 1'b0;
    @(negedge clk);
    rst[inst] = 1'b0;
  endtask

  // Wait (bounded) for a response, pop the expectation queued at request time and compare.
  task automatic await_result(input string name, input int inst, output logic got);
    int   cyc;
    exp_t e;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < TIMEOUT) begin
      @(negedge clk);
      cyc++;
      got = succ[inst] | fl[inst];
    end
    e = sb_q.pop_front();
    check({name, " responded"}, 32'(got), 32'(1'b1));
    if (got) begin
      check({name, " latency"}, cyc, RD_LAT + 2);
      check({name, " success"}, 32'(succ[inst]), 32'(e.ok));
      check({name, " fail"},    32'(fl[inst]),   32'(!e.ok));
      check({name, " state"},   32'(st[inst]),   32'(e.state));
      check({name, " debug"},   32'(dbg[inst]),  32'(e.dbg));
      check({name, " busy"},    32'(bsy[inst]),  32'(1'b1));
    end
  endtask

  task automatic run_txn(input string name, input int inst, input int t, input int sig,
                         input logic bad, input logic ok, input int state, input logic lock);
    exp_t e;
    logic got;
    e.ok = ok; e.state = state; e.dbg = (state <= DEBUG_MAX); e.lock = lock;
    @(negedge clk);
    tgt[inst] = STATE_W'(t);
    id[inst]  = ident(sig, bad);
    req[inst] = 1'b1;
    sb_q.push_back(e);
    await_result(name, inst, got);
    if (got) begin
      @(negedge clk);
      check({name, " held"}, 32'(succ[inst] | fl[inst]), 32'(1'b1));
    end
    req[inst] = 1'b0;
    @(negedge clk);
    check_idle({name, " after"}, inst, state, lock);
  endtask

  vec_t vecs[16];
  int   seen;
  logic got;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{0, 1, 0, 1'b0, 1'b1, 1, 0, 1'b0};
    vecs[1]  = '{0, 3, 1, 1'b0, 1'b0, 1, 0, 1'b0};
    vecs[2]  = '{0, 2, 1, 1'b1, 1'b0, 1, 1, 1'b0};
    vecs[3]  = '{0, 2, 1, 1'b0, 1'b1, 2, 0, 1'b0};
    vecs[4]  = '{1, 1, 0, 1'b0, 1'b1, 1, 0, 1'b0};
    vecs[5]  = '{1, 3, 1, 1'b0, 1'b1, 3, 0, 1'b0};
    vecs[6]  = '{1, 2, 3, 1'b0, 1'b0, 3, 0, 1'b0};
    vecs[7]  = '{1, 3, 3, 1'b0, 1'b0, 3, 0, 1'b0};
    vecs[8]  = '{1, 4, 3, 1'b0, 1'b1, 4, 0, 1'b0};
    vecs[9]  = '{1, 6, 4, 1'b0, 1'b0, 4, 0, 1'b0};
    vecs[10] = '{1, 5, 4, 1'b0, 1'b1, 5, 0, 1'b0};
    vecs[11] = '{1, 5, 5, 1'b0, 1'b0, 5, 0, 1'b0};
    vecs[12] = '{1, 5, 5, 1'b1, 1'b0, 5, 0, 1'b0};
    vecs[13] = '{0, 3, 2, 1'b1, 1'b0, 2, 1, 1'b0};
    vecs[14] = '{0, 3, 2, 1'b1, 1'b0, 2, 2, 1'b0};
    vecs[15] = '{0, 3, 2, 1'b1, 1'b0, 2, 3, 1'b1};

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; req[i] = 1'b0; tgt[i] = '0; id[i] = '0;
    end
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    check_idle("reset u0", 0, 0, 1'b0);
    check_idle("reset u1", 1, 0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].inst, vecs[i].tgt, vecs[i].sig,
              vecs[i].bad_id, vecs[i].ok, vecs[i].state, vecs[i].lock);
      check($sformatf("vec%0d fail_cnt", i), fail_cnt(vecs[i].inst), vecs[i].fcnt);
    end

    // Locked: a correct request gets no response at all.
    @(negedge clk);
    tgt[0] = 3'd3; id[0] = ident(2, 1'b0); req[0] = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (succ[0] || fl[0] || bsy[0]) seen++;
    end
    check("locked no response", seen, 0);
    check("locked state", 32'(st[0]), 32'(2));
    check("locked flag", 32'(lck[0]), 32'(1'b1));
    req[0] = 1'b0;
    do_reset(0);
    check_idle("unlock reset", 0, 0, 1'b0);
    check("unlock fail_cnt", fail_cnt(0), 0);

    // Request dropped during FETCH: result still applied, pulse lasts one cycle.
    begin
      exp_t e;
      e.ok = 1'b1; e.state = 1; e.dbg = 1'b1; e.lock = 1'b0;
      @(negedge clk);
      tgt[0] = 3'd1; id[0] = ident(0, 1'b0); req[0] = 1'b1;
      sb_q.push_back(e);
      @(negedge clk);
      req[0] = 1'b0;
      check("drop busy", 32'(bsy[0]), 32'(1'b1));
      // One cycle already elapsed, so the remaining wait is RD_LAT+1; compare via own count.
      seen = 0;
      got  = 1'b0;
      while (!got && seen < TIMEOUT) begin
        @(negedge clk);
        seen++;
        got = succ[0] | fl[0];
      end
      e = sb_q.pop_front();
      check("drop responded", 32'(got), 32'(1'b1));
      check("drop latency", seen + 1, RD_LAT + 2);
      check("drop success", 32'(succ[0]), 32'(e.ok));
      check("drop state", 32'(st[0]), 32'(e.state));
      @(negedge clk);
      check_idle("drop after", 0, 1, 1'b0);
    end

    // Reset while in FETCH aborts the transaction without any pulse.
    @(negedge clk);
    tgt[0] = 3'd2; id[0] = ident(1, 1'b0); req[0] = 1'b1;
    @(negedge clk);
    check("abort busy before", 32'(bsy[0]), 32'(1'b1));
    rst[0] = 1'b1;
    req[0] = 1'b0;
    @(negedge clk);
    rst[0] = 1'b0;
    check_idle("abort", 0, 0, 1'b0);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (succ[0] || fl[0] || bsy[0]) seen++;
    end
    check("abort no pulse", seen, 0);
    check("abort final state", 32'(st[0]), 32'(0));

    check("scoreboard drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
